// File: rtl/pc_debug_rx_if.sv
// Decoded-PC stream port: the receiver drives valid/data, the consumer drives ready.
interface pc_debug_rx_if #(
  parameter int PC_W = 19
);
  logic            pc_valid;
  logic            pc_ready;
  logic [PC_W-1:0] pc_data;

  modport master (output pc_valid, output pc_data, input pc_ready);
  modport slave  (input pc_valid, input pc_data, output pc_ready);
endinterface

// File: rtl/pc_debug_rx.sv
// Serial PC debug line receiver: start-bit hunt, chained MSB-first frame
// deserialization and a small decoded-PC FIFO drained by valid/ready.
module pc_debug_rx #(
  parameter int PC_W       = 19,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_serial_in,
  input  logic              stop_req,
  input  logic              clr,
  pc_debug_rx_if.master     pc_if,
  output logic [PC_W-1:0]   last_pc,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              overflow,
  output logic              busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(PC_W);

  typedef enum logic {HUNT = 1'b0, RECV = 1'b1} state_t;

  state_t            state_reg, state_next;
  logic [BW-1:0]     bit_cnt_reg;
  logic [PC_W-2:0]   shift_reg;
  logic              stop_flag_reg;
  logic [PC_W-1:0]   mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_reg, rd_ptr_reg;

  logic              frame_done;
  logic              stream_end;
  logic [PC_W-1:0]   frame_word;
  logic              fifo_empty, fifo_full;
  logic              push, pop;

  assign frame_done = (state_reg == RECV) && (bit_cnt_reg == BW'(PC_W-1));
  assign frame_word = {shift_reg, pc_serial_in};
  // A stop request on the LSB cycle itself still ends the stream.
  assign stream_end = frame_done & (stop_flag_reg | stop_req);

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop        = ~fifo_empty & pc_if.pc_ready;
  assign push       = frame_done & (~fifo_full | pop);

  assign pc_if.pc_valid = ~fifo_empty;
  assign pc_if.pc_data  = fifo_empty ? '0 : mem[rd_ptr_reg[AW-1:0]];
  assign busy           = (state_reg == RECV);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      HUNT: if (pc_serial_in) state_next = RECV;
      RECV: if (stream_end)   state_next = HUNT;
      default: state_next = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= HUNT;
    end else if (clr) begin
      state_reg <= HUNT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      stop_flag_reg <= 1'b0;
      last_pc       <= '0;
      frame_cnt     <= '0;
      overflow      <= 1'b0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
    end else if (clr) begin
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      stop_flag_reg <= 1'b0;
      last_pc       <= '0;
      frame_cnt     <= '0;
      overflow      <= 1'b0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
    end else begin
      if (state_reg == HUNT) begin
        if (pc_serial_in) begin
          bit_cnt_reg   <= '0;
          stop_flag_reg <= 1'b0;
        end
      end else begin
        shift_reg <= frame_word[PC_W-2:0];
        if (frame_done) begin
          bit_cnt_reg   <= '0;
          stop_flag_reg <= 1'b0;
          last_pc       <= frame_word;
          frame_cnt     <= frame_cnt + CNT_W'(1);
          if (!push) overflow <= 1'b1;
        end else begin
          bit_cnt_reg <= bit_cnt_reg + BW'(1);
          if (stop_req) stop_flag_reg <= 1'b1;
        end
      end
      if (push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= frame_word;
  end
endmodule

// File: tb/tb_pc_debug_rx.sv
// Self-checking bench for pc_debug_rx: directed scenarios plus randomized
// streams, compared every cycle against a queue-based model of the receiver.
module tb_pc_debug_rx;
  localparam int PC_W = 19;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W = 16;

  logic clk = 0;
  logic rst_n = 0;
  logic pc_serial_in = 0;
  logic stop_req = 0;
  logic clr = 0;
  logic [PC_W-1:0]  last_pc;
  logic [CNT_W-1:0] frame_cnt;
  logic overflow, busy;

  pc_debug_rx_if #(.PC_W(PC_W)) pc_if ();

  pc_debug_rx #(.PC_W(PC_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .pc_serial_in(pc_serial_in), .stop_req(stop_req),
    .clr(clr), .pc_if(pc_if), .last_pc(last_pc), .frame_cnt(frame_cnt),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  bit cmp_en = 0;
  int rdy_mode = 0;  // 0: hold, 1: random per cycle, 2: low unless forced

  // Transmitter-side event flags, set on the cycle the corresponding bit is driven.
  bit ev_start = 0, ev_lsb = 0, ev_stop = 0;
  logic [PC_W-1:0] ev_val = '0;

  // Reference model state.
  logic [PC_W-1:0]  mq[$];
  logic [PC_W-1:0]  m_last = '0;
  logic [CNT_W-1:0] m_cnt = '0;
  bit m_ovf = 0, m_busy = 0;

  logic [PC_W-1:0] tx_q[$];
  logic [PC_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge rst_n) begin
    mq.delete(); m_last = '0; m_cnt = '0; m_ovf = 0; m_busy = 0;
  end

  always @(posedge clk) begin : model
    bit popped, was_full;
    if (rst_n) begin
      if (clr) begin
        mq.delete(); m_last = '0; m_cnt = '0; m_ovf = 0; m_busy = 0;
      end else begin
        popped = 0;
        was_full = (mq.size() == FIFO_DEPTH);
        if (mq.size() > 0 && pc_if.pc_ready) begin
          void'(mq.pop_front());
          popped = 1;
        end
        if (ev_start) m_busy = 1;
        if (ev_lsb) begin
          m_last = ev_val;
          m_cnt  = m_cnt + 1'b1;
          if (!was_full || popped) mq.push_back(ev_val);
          else m_ovf = 1;
          if (ev_stop) m_busy = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pc_valid", pc_if.pc_valid, (mq.size() != 0));
      chk("pc_data", pc_if.pc_data, (mq.size() != 0) ? mq[0] : '0);
      chk("last_pc", last_pc, m_last);
      chk("frame_cnt", frame_cnt, m_cnt);
      chk("overflow", overflow, m_ovf);
      chk("busy", busy, m_busy);
    end
  end

  task automatic step(input logic b, input logic s);
    @(negedge clk);
    ev_start = 0; ev_lsb = 0; ev_stop = 0; clr = 0;
    if (rdy_mode == 1) pc_if.pc_ready = 1'($urandom_range(0, 1));
    else if (rdy_mode == 2) pc_if.pc_ready = 0;
    pc_serial_in = b;
    stop_req = s;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 1'($urandom_range(0, 1)));
  endtask

  task automatic do_clr();
    step(0, 0);
    clr = 1;
    step(0, 0);
  endtask

  task automatic send_frame(input logic [PC_W-1:0] v, input bit do_stop, input int stop_bit,
                            input int abort_bit, input bit abort_rst, input bit pop_lsb);
    for (int i = 0; i < PC_W; i++) begin
      step(v[PC_W-1-i], do_stop && (i >= stop_bit));
      if (i == abort_bit) begin
        if (abort_rst) begin
          #2 rst_n = 0;
          #1;
          chk("rst_valid", pc_if.pc_valid, 0);
          chk("rst_data", pc_if.pc_data, 0);
          chk("rst_last", last_pc, 0);
          chk("rst_cnt", frame_cnt, 0);
          chk("rst_busy", busy, 0);
        end else begin
          clr = 1;
        end
        return;
      end
      if (i == PC_W - 1) begin
        ev_lsb = 1; ev_val = v; ev_stop = do_stop;
        if (pop_lsb) pc_if.pc_ready = 1;
      end
    end
  endtask

  task automatic send_stream(input int stop_bit, input int pop_idx);
    step(1, 1'($urandom_range(0, 1)));
    ev_start = 1;
    for (int k = 0; k < tx_q.size(); k++)
      send_frame(tx_q[k], k == tx_q.size() - 1, stop_bit, -1, 0, k == pop_idx);
  endtask

  task automatic expect_pops();
    for (int k = 0; k < exp_q.size(); k++) begin
      step(0, 0);
      chk("pop_valid", pc_if.pc_valid, 1);
      chk("pop_data", pc_if.pc_data, exp_q[k]);
      pc_if.pc_ready = 1;
    end
    step(0, 0);
    pc_if.pc_ready = 0;
  endtask

  initial begin
    pc_if.pc_ready = 0;
    repeat (3) @(negedge clk);
    chk("reset_valid", pc_if.pc_valid, 0);
    chk("reset_cnt", frame_cnt, 0);
    chk("reset_busy", busy, 0);
    rst_n = 1;
    cmp_en = 1;

    // Single frame with stop mid-frame.
    idle(5);
    tx_q = '{19'h12345};
    send_stream(9, -1);
    step(0, 0);
    chk("single_data", pc_if.pc_data, 19'h12345);
    chk("single_cnt", frame_cnt, 1);
    chk("single_busy", busy, 0);
    exp_q = '{19'h12345};
    expect_pops();

    // Chained frames with the consumer always ready.
    do_clr();
    pc_if.pc_ready = 1;
    tx_q = '{19'h00001, 19'h00000, 19'h7FFFF};
    send_stream(5, -1);
    step(0, 0);
    chk("chain_cnt", frame_cnt, 3);
    chk("chain_last", last_pc, 19'h7FFFF);
    chk("chain_busy", busy, 0);
    pc_if.pc_ready = 0;

    // Overflow: six frames into a four-entry FIFO.
    do_clr();
    tx_q = '{19'd1, 19'd2, 19'd3, 19'd4, 19'd5, 19'd6};
    send_stream(0, -1);
    step(0, 0);
    chk("ovf_flag", overflow, 1);
    chk("ovf_last", last_pc, 19'd6);
    chk("ovf_cnt", frame_cnt, 6);
    exp_q = '{19'd1, 19'd2, 19'd3, 19'd4};
    expect_pops();
    chk("ovf_empty", pc_if.pc_valid, 0);

    // Full FIFO with a pop on frame 5's LSB edge.
    do_clr();
    rdy_mode = 2;
    tx_q = '{19'd1, 19'd2, 19'd3, 19'd4, 19'd5};
    send_stream(0, 4);
    step(0, 0);
    chk("fullpop_ovf", overflow, 0);
    exp_q = '{19'd2, 19'd3, 19'd4, 19'd5};
    expect_pops();
    rdy_mode = 0;

    // Stop only on the LSB cycle, restart on the very next cycle.
    do_clr();
    tx_q = '{19'h00155};
    send_stream(PC_W - 1, -1);
    tx_q = '{19'h0ABCD};
    send_stream(3, -1);
    step(0, 0);
    chk("restart_last", last_pc, 19'h0ABCD);
    chk("restart_cnt", frame_cnt, 2);

    // clr at bit 7 with two entries queued.
    do_clr();
    tx_q = '{19'h00011, 19'h00022};
    send_stream(0, -1);
    step(1, 0);
    ev_start = 1;
    send_frame(19'h7FFFF, 0, 0, 7, 0, 0);
    idle(4);
    chk("clr_valid", pc_if.pc_valid, 0);
    chk("clr_cnt", frame_cnt, 0);
    chk("clr_busy", busy, 0);

    // Reset at bit 7 with two entries queued.
    tx_q = '{19'h00033, 19'h00044};
    send_stream(0, -1);
    step(1, 0);
    ev_start = 1;
    send_frame(19'h7FFFF, 0, 0, 7, 1, 0);
    step(0, 0);
    rst_n = 1;
    idle(3);
    chk("rst_after_busy", busy, 0);

    // Randomized streams with a randomly stalling consumer.
    rdy_mode = 1;
    for (int s = 0; s < 40; s++) begin
      tx_q.delete();
      for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
        case ($urandom_range(0, 7))
          0: tx_q.push_back('0);
          1: tx_q.push_back('1);
          default: tx_q.push_back(PC_W'($urandom));
        endcase
      end
      send_stream(int'($urandom_range(0, PC_W - 1)), -1);
      idle(int'($urandom_range(0, 4)));
      if ($urandom_range(0, 9) == 0) do_clr();
    end
    rdy_mode = 0;
    pc_if.pc_ready = 0;
    idle(3);
    cmp_en = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
